p_reg_unit: RTL and testbench
=============================

Name: p_reg_unit

Overview:
- Processor status (P) register. It consumes the flag results produced by the ALU (carry, overflow, zero, negative) and by the data bus.
- It holds N V D I Z C and supplies the stacked image for PHP/BRK/IRQ/NMI.
- It drives the decimal-mode and IRQ-mask signals back into the datapath, and evaluates 6502 branch conditions.
- It sits between the ALU/z-flag logic and the control sequencer. It is the flag-consuming end of the ALU interface.

Parameters:
- CMOS_CLD_ON_INT, 0: when 1, interrupt entry also clears D (65C02 behaviour).
- IRQ_MASK_DELAY, 1: number of ce-qualified cycles by which irq_mask lags the I bit for CLI/SEI/PLP. Legal values are 0–2.

Ports:
- clk  in  1  core clock.
- reset_n  in  1  asynchronous active-low reset.
- ce  in  1  clock enable (RDY). When 0, all state holds.
- alu_c  in  1  ALU carry_out.
- alu_v  in  1  ALU overflow_out.
- alu_z  in  1  z-flag unit z_out.
- alu_n  in  1  ALU result bit 7.
- db_in  in  8  data bus, used for PLP/RTI and BIT.
- ld_nz  in  1  load N from alu_n and Z from alu_z.
- ld_c  in  1  load C from alu_c.
- ld_v  in  1  load V from alu_v.
- ld_bit  in  1  BIT: N<=db_in[7], V<=db_in[6].
- ld_p  in  1  PLP/RTI: load N V D I Z C from db_in[7,6,3,2,1,0].
- flag_op_en  in  1  perform flag_op this cycle.
- flag_op  in  3  one of CLC SEC CLI SEI CLD SED CLV.
- int_entry  in  1  interrupt/BRK entry: set I (and clear D if CMOS_CLD_ON_INT).
- push_b  in  1  value of the B bit in p_push (1 for PHP/BRK, 0 for IRQ/NMI).
- br_cond  in  3  opcode[7:5] of the branch instruction.
- p_out  out  8  {N,V,1,1,D,I,Z,C}.
- p_push  out  8  {N,V,1,push_b,D,I,Z,C}, combinational.
- dec_mode  out  1  registered D, fed to the dec_add/dec_sub qualifiers.
- irq_mask  out  1  delayed I used by the IRQ sampler.
- br_taken  out  1  combinational branch decision from the current flags.

Behaviour:
- Reset (async, reset_n=0):
  - N=V=D=Z=C=0, I=1.
  - p_out=8'h34 (bit 5 =1, bit 4 reads 1, I=1); irq_mask=1; dec_mode=0.
  - The delay pipe is all 1s.
  - Reset may assert mid-instruction; all state is forced immediately, independent of clk and ce.
- Updates:
  - Flags update on posedge clk only when ce=1.
  - Results are visible on p_out in the cycle after the load strobe; there is no combinational bypass.
- Priority per cycle (highest first):
  - ld_p.
  - int_entry, which controls I and D only.
  - flag_op_en.
  - Individual loads.
- Overlap rules:
  - A lower-priority source never modifies a bit owned by a higher-priority active source.
  - Non-conflicting sources combine. Example: ld_nz+ld_c+ld_v together update N, Z, C, V in one edge.
  - ld_bit together with ld_nz: N and V come from db_in, Z comes from alu_z.
  - flag_op CLV together with ld_v: V=0.
- flag_op codes undefined in the package are no-ops.
- irq_mask:
  - With IRQ_MASK_DELAY=N, irq_mask equals the value of I N ce-cycles earlier, shifted on ce=1 edges.
  - int_entry bypasses the pipe: irq_mask and the whole pipe are set to 1 on the same edge.
  - With delay 0, irq_mask equals I.
- dec_mode = D register, updated on the same edge as D.
- br_taken decode:
  - 000 !N, 001 N, 010 !V, 011 V, 100 !C, 101 C, 110 !Z, 111 Z.
  - It is evaluated against the registered flags only.
- p_push is purely combinational from the registered flags and push_b.

Decomposition:
- Constants go into the shared 6502 include (6502_inc.vh): flag bit indices, the kFLAG_* flag_op codes, the kBR_* branch codes, and the reset P value.
- One natural sub-module: p_irq_mask_delay. It is a parameterised shift pipe with set-all bypass and ce qualification.
- Branch decode stays inline as an 8-way case.

Test Plan:
1. Reset, then release:
   - p_out=8'h34, irq_mask=1, dec_mode=0.
   - br_cond=3'b100 (BCC) gives br_taken=1.
2. alu_c=1, alu_v=1, alu_n=1, alu_z=0 with ld_nz, ld_c, ld_v for one ce cycle:
   - The next cycle gives p_out=8'hF1 (I was cleared earlier by CLI).
   - Same cycle as the strobe: p_out unchanged.
3. ld_p with db_in=8'h00 while ld_c=1 and alu_c=1 → C=0 (ld_p wins); p_out=8'h30.
4. CLI (flag_op_en) with IRQ_MASK_DELAY=1:
   - p_out bit 2 clears after 1 edge; irq_mask clears one edge later.
   - int_entry the following cycle sets I and irq_mask together on the same edge.
5. SED, then int_entry with CMOS_CLD_ON_INT=1 → D=0, dec_mode=0.
   - With CMOS_CLD_ON_INT=0, D stays 1.
   - p_push with push_b=0 shows bit 4=0, bit 5=1.
6. Hold ce=0 while strobing ld_c and flag_op SEC → no change.
   - Assert reset_n=0 between clock edges → p_out=8'h34 immediately.

Source files
------------

// File: rtl/p_reg_unit_pkg.sv
// Shared 6502 status-register constants: flag bit positions, flag_op and branch codes, reset image.
package p_reg_unit_pkg;

    localparam int unsigned kP_C = 0;
    localparam int unsigned kP_Z = 1;
    localparam int unsigned kP_I = 2;
    localparam int unsigned kP_D = 3;
    localparam int unsigned kP_B = 4;
    localparam int unsigned kP_U = 5;
    localparam int unsigned kP_V = 6;
    localparam int unsigned kP_N = 7;

    localparam logic [2:0] kFLAG_CLC = 3'd0;
    localparam logic [2:0] kFLAG_SEC = 3'd1;
    localparam logic [2:0] kFLAG_CLI = 3'd2;
    localparam logic [2:0] kFLAG_SEI = 3'd3;
    localparam logic [2:0] kFLAG_CLD = 3'd4;
    localparam logic [2:0] kFLAG_SED = 3'd5;
    localparam logic [2:0] kFLAG_CLV = 3'd6;

    localparam logic [2:0] kBR_BPL = 3'b000;
    localparam logic [2:0] kBR_BMI = 3'b001;
    localparam logic [2:0] kBR_BVC = 3'b010;
    localparam logic [2:0] kBR_BVS = 3'b011;
    localparam logic [2:0] kBR_BCC = 3'b100;
    localparam logic [2:0] kBR_BCS = 3'b101;
    localparam logic [2:0] kBR_BNE = 3'b110;
    localparam logic [2:0] kBR_BEQ = 3'b111;

    localparam logic [7:0] kP_RESET = 8'h34;

    typedef struct packed {
        logic n;
        logic v;
        logic d;
        logic i;
        logic z;
        logic c;
    } flags_t;

    localparam flags_t kFLAGS_RESET = '{n: 1'b0, v: 1'b0, d: 1'b0, i: 1'b1, z: 1'b0, c: 1'b0};

endpackage

// File: rtl/p_reg_unit_irq_mask_delay.sv
// IRQ mask delay pipe: I shifted through DEPTH ce-qualified stages, with a set-all bypass.
module p_irq_mask_delay #(
    parameter int unsigned DEPTH = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic ce,
    input  logic set_all,
    input  logic i_bit,
    output logic mask
);

    localparam int unsigned PW = (DEPTH == 0) ? 1 : DEPTH;

    logic [PW-1:0] pipe;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pipe <= '1;
        end else if (ce) begin
            if (set_all) begin
                pipe <= '1;
            end else begin
                pipe[0] <= i_bit;
                for (int unsigned k = 1; k < PW; k++) begin
                    pipe[k] <= pipe[k-1];
                end
            end
        end
    end

    // With no delay the mask follows the registered I directly.
    assign mask = (DEPTH == 0) ? i_bit : pipe[PW-1];

endmodule

// File: rtl/p_reg_unit.sv
// 6502 processor status register: flag loads, stacked image, IRQ mask delay, branch decode.
module p_reg_unit
    import p_reg_unit_pkg::*;
#(
    parameter bit          CMOS_CLD_ON_INT = 1'b0,
    parameter int unsigned IRQ_MASK_DELAY  = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ce,
    input  logic       alu_c,
    input  logic       alu_v,
    input  logic       alu_z,
    input  logic       alu_n,
    input  logic [7:0] db_in,
    input  logic       ld_nz,
    input  logic       ld_c,
    input  logic       ld_v,
    input  logic       ld_bit,
    input  logic       ld_p,
    input  logic       flag_op_en,
    input  logic [2:0] flag_op,
    input  logic       int_entry,
    input  logic       push_b,
    input  logic [2:0] br_cond,
    output logic [7:0] p_out,
    output logic [7:0] p_push,
    output logic       dec_mode,
    output logic       irq_mask,
    output logic       br_taken
);

    flags_t flags_q;
    flags_t flags_d;

    // Sources applied lowest priority first so higher ones overwrite only the bits they own.
    always_comb begin
        flags_d = flags_q;
        if (ld_nz) begin
            flags_d.n = alu_n;
            flags_d.z = alu_z;
        end
        if (ld_c) flags_d.c = alu_c;
        if (ld_v) flags_d.v = alu_v;
        if (ld_bit) begin
            flags_d.n = db_in[kP_N];
            flags_d.v = db_in[kP_V];
        end
        if (flag_op_en) begin
            case (flag_op)
                kFLAG_CLC: flags_d.c = 1'b0;
                kFLAG_SEC: flags_d.c = 1'b1;
                kFLAG_CLI: flags_d.i = 1'b0;
                kFLAG_SEI: flags_d.i = 1'b1;
                kFLAG_CLD: flags_d.d = 1'b0;
                kFLAG_SED: flags_d.d = 1'b1;
                kFLAG_CLV: flags_d.v = 1'b0;
                default:   ;
            endcase
        end
        if (int_entry) begin
            flags_d.i = 1'b1;
            if (CMOS_CLD_ON_INT) flags_d.d = 1'b0;
        end
        if (ld_p) begin
            flags_d.n = db_in[kP_N];
            flags_d.v = db_in[kP_V];
            flags_d.d = db_in[kP_D];
            flags_d.i = db_in[kP_I];
            flags_d.z = db_in[kP_Z];
            flags_d.c = db_in[kP_C];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flags_q <= kFLAGS_RESET;
        end else if (ce) begin
            flags_q <= flags_d;
        end
    end

    p_irq_mask_delay #(
        .DEPTH(IRQ_MASK_DELAY)
    ) u_irq_mask_delay (
        .clk    (clk),
        .reset_n(reset_n),
        .ce     (ce),
        .set_all(int_entry & ~ld_p),
        .i_bit  (flags_q.i),
        .mask   (irq_mask)
    );

    assign p_out    = {flags_q.n, flags_q.v, 1'b1, 1'b1, flags_q.d, flags_q.i, flags_q.z, flags_q.c};
    assign p_push   = {flags_q.n, flags_q.v, 1'b1, push_b, flags_q.d, flags_q.i, flags_q.z, flags_q.c};
    assign dec_mode = flags_q.d;

    always_comb begin
        br_taken = 1'b0;
        case (br_cond)
            kBR_BPL: br_taken = ~flags_q.n;
            kBR_BMI: br_taken =  flags_q.n;
            kBR_BVC: br_taken = ~flags_q.v;
            kBR_BVS: br_taken =  flags_q.v;
            kBR_BCC: br_taken = ~flags_q.c;
            kBR_BCS: br_taken =  flags_q.c;
            kBR_BNE: br_taken = ~flags_q.z;
            kBR_BEQ: br_taken =  flags_q.z;
            default: br_taken = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_p_reg_unit.sv
// Directed bench for p_reg_unit: NMOS/CMOS interrupt-entry variants and a two-stage IRQ mask pipe.
module tb_p_reg_unit;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       ce;
    logic       alu_c, alu_v, alu_z, alu_n;
    logic [7:0] db_in;
    logic       ld_nz, ld_c, ld_v, ld_bit, ld_p;
    logic       flag_op_en;
    logic [2:0] flag_op;
    logic       int_entry;
    logic       push_b;
    logic [2:0] br_cond;

    logic [7:0] p_out_a, p_push_a, p_out_b, p_push_b_unused, p_out_c, p_push_c;
    logic       dec_a, irq_a, br_a;
    logic       dec_b, irq_b, br_b;
    logic       dec_c, irq_c, br_c;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    p_reg_unit #(.CMOS_CLD_ON_INT(1'b0), .IRQ_MASK_DELAY(1)) u_a (
        .clk(clk), .reset_n(reset_n), .ce(ce),
        .alu_c(alu_c), .alu_v(alu_v), .alu_z(alu_z), .alu_n(alu_n), .db_in(db_in),
        .ld_nz(ld_nz), .ld_c(ld_c), .ld_v(ld_v), .ld_bit(ld_bit), .ld_p(ld_p),
        .flag_op_en(flag_op_en), .flag_op(flag_op), .int_entry(int_entry), .push_b(push_b),
        .br_cond(br_cond), .p_out(p_out_a), .p_push(p_push_a), .dec_mode(dec_a),
        .irq_mask(irq_a), .br_taken(br_a)
    );

    p_reg_unit #(.CMOS_CLD_ON_INT(1'b1), .IRQ_MASK_DELAY(1)) u_b (
        .clk(clk), .reset_n(reset_n), .ce(ce),
        .alu_c(alu_c), .alu_v(alu_v), .alu_z(alu_z), .alu_n(alu_n), .db_in(db_in),
        .ld_nz(ld_nz), .ld_c(ld_c), .ld_v(ld_v), .ld_bit(ld_bit), .ld_p(ld_p),
        .flag_op_en(flag_op_en), .flag_op(flag_op), .int_entry(int_entry), .push_b(push_b),
        .br_cond(br_cond), .p_out(p_out_b), .p_push(p_push_b_unused), .dec_mode(dec_b),
        .irq_mask(irq_b), .br_taken(br_b)
    );

    p_reg_unit #(.CMOS_CLD_ON_INT(1'b0), .IRQ_MASK_DELAY(2)) u_c (
        .clk(clk), .reset_n(reset_n), .ce(ce),
        .alu_c(alu_c), .alu_v(alu_v), .alu_z(alu_z), .alu_n(alu_n), .db_in(db_in),
        .ld_nz(ld_nz), .ld_c(ld_c), .ld_v(ld_v), .ld_bit(ld_bit), .ld_p(ld_p),
        .flag_op_en(flag_op_en), .flag_op(flag_op), .int_entry(int_entry), .push_b(push_b),
        .br_cond(br_cond), .p_out(p_out_c), .p_push(p_push_c), .dec_mode(dec_c),
        .irq_mask(irq_c), .br_taken(br_c)
    );

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_strobes();
        ld_nz = 0; ld_c = 0; ld_v = 0; ld_bit = 0; ld_p = 0;
        flag_op_en = 0; flag_op = 3'd0; int_entry = 0;
    endtask

    initial begin
        reset_n = 1; ce = 1;
        alu_c = 0; alu_v = 0; alu_z = 0; alu_n = 0; db_in = 8'h00;
        push_b = 1; br_cond = 3'b100;
        clear_strobes();
        #1 reset_n = 0;
        #1;
        check("reset_p_out", p_out_a, 8'h34);
        check("reset_irq_mask", {7'd0, irq_a}, 8'h01);
        check("reset_dec_mode", {7'd0, dec_a}, 8'h00);
        check("reset_bcc_taken", {7'd0, br_a}, 8'h01);
        tick();
        check("reset_held_over_edge", p_out_a, 8'h34);
        reset_n = 1;
        tick();
        check("after_release", p_out_c, 8'h34);

        // CLI: I clears after one edge, irq_mask one edge later (two for the deep pipe)
        flag_op_en = 1; flag_op = 3'd2;
        tick();
        clear_strobes();
        check("cli_p_out", p_out_a, 8'h30);
        check("cli_irq_still_set", {7'd0, irq_a}, 8'h01);
        tick();
        check("cli_irq_cleared", {7'd0, irq_a}, 8'h00);
        check("cli_irq_deep_still_set", {7'd0, irq_c}, 8'h01);
        tick();
        check("cli_irq_deep_cleared", {7'd0, irq_c}, 8'h00);

        // combined ld_nz/ld_c/ld_v
        alu_c = 1; alu_v = 1; alu_n = 1; alu_z = 0;
        ld_nz = 1; ld_c = 1; ld_v = 1;
        #1;
        check("no_bypass_same_cycle", p_out_a, 8'h30);
        tick();
        clear_strobes();
        check("nzcv_load", p_out_a, 8'hF1);

        // BIT with ld_nz: N,V from db_in, Z from alu_z
        db_in = 8'h40; alu_n = 1; alu_z = 1;
        ld_bit = 1; ld_nz = 1;
        tick();
        clear_strobes();
        check("bit_with_nz", p_out_a, 8'h73);

        // CLV overrides ld_v
        alu_v = 1; ld_v = 1; flag_op_en = 1; flag_op = 3'd6;
        tick();
        clear_strobes();
        check("clv_over_ld_v", p_out_a, 8'h33);

        flag_op_en = 1; flag_op = 3'd7;
        tick();
        clear_strobes();
        check("undefined_flag_op", p_out_a, 8'h33);

        // ld_p beats ld_c
        db_in = 8'h00; alu_c = 1; ld_c = 1; ld_p = 1;
        tick();
        clear_strobes();
        check("ld_p_over_ld_c", p_out_a, 8'h30);
        for (int k = 0; k < 8; k++) begin
            br_cond = 3'(k);
            #1;
            check($sformatf("br_clear_%0d", k), {7'd0, br_a}, {7'd0, ~br_cond[0]});
        end

        db_in = 8'hCB; ld_p = 1;
        tick();
        clear_strobes();
        check("ld_p_cb", p_out_a, 8'hFB);
        check("ld_p_dec_mode", {7'd0, dec_a}, 8'h01);
        for (int k = 0; k < 8; k++) begin
            br_cond = 3'(k);
            #1;
            check($sformatf("br_set_%0d", k), {7'd0, br_a}, {7'd0, br_cond[0]});
        end

        flag_op_en = 1; flag_op = 3'd4;
        tick();
        clear_strobes();
        check("cld", p_out_a, 8'hF3);
        check("cld_dec_mode", {7'd0, dec_a}, 8'h00);
        flag_op_en = 1; flag_op = 3'd5;
        tick();
        clear_strobes();
        check("sed", p_out_a, 8'hFB);
        check("sed_dec_mode", {7'd0, dec_b}, 8'h01);

        push_b = 0;
        #1;
        check("p_push_b0", p_push_a, 8'hEB);
        push_b = 1;
        #1;
        check("p_push_b1", p_push_c, 8'hFB);
        check("irq_before_int", {7'd0, irq_a}, 8'h00);

        // interrupt entry: I and irq_mask set on the same edge; CMOS variant also clears D
        int_entry = 1;
        tick();
        clear_strobes();
        check("int_nmos_p_out", p_out_a, 8'hFF);
        check("int_nmos_irq", {7'd0, irq_a}, 8'h01);
        check("int_nmos_dec", {7'd0, dec_a}, 8'h01);
        check("int_cmos_p_out", p_out_b, 8'hF7);
        check("int_cmos_dec", {7'd0, dec_b}, 8'h00);
        check("int_cmos_irq", {7'd0, irq_b}, 8'h01);
        check("int_deep_irq", {7'd0, irq_c}, 8'h01);

        // ce=0 holds everything
        ce = 0; alu_c = 0; ld_c = 1; flag_op_en = 1; flag_op = 3'd0;
        db_in = 8'h00; ld_p = 1;
        tick();
        tick();
        check("ce_hold_p_out", p_out_a, 8'hFF);
        check("ce_hold_cmos", p_out_b, 8'hF7);
        clear_strobes();
        ce = 1;

        #2 reset_n = 0;
        #1;
        check("async_reset_p_out", p_out_a, 8'h34);
        check("async_reset_cmos", p_out_b, 8'h34);
        check("async_reset_dec", {7'd0, dec_a}, 8'h00);
        check("async_reset_irq", {7'd0, irq_a}, 8'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
